// File: rtl/weight_buffer.sv
// Loadable weight/bias store for M layers of N neurons. A layer is returned one row per cycle into weights_out.
// Optional per-word even parity (define WB_PARITY_EN); without it parity_err is tied low.
module weight_buffer #(
  parameter int N     = 4,
  parameter int M     = 3,
  parameter int WIDTH = 16,
  localparam int LW   = (M > 1) ? $clog2(M) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ld_start,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [WIDTH-1:0]             ld_data,
  output logic                         loaded,
  input  logic                         rd_req,
  input  logic [LW-1:0]                rd_layer,
  output logic                         rd_ready,
  output logic                         rd_valid,
  output logic                         rd_err,
  output logic [N-1:0][N:0][WIDTH-1:0] weights_out,
  output logic                         parity_err
);
  localparam int ROWS = M * N;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IW   = $clog2(N + 1);
  localparam int PW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RDY, READ} state_t;
  state_t state, state_nx;

  logic [RW-1:0] wrow, rrow;
  logic [IW-1:0] widx;
  logic [PW-1:0] rptr;
  logic [N:0][WIDTH-1:0] mem [ROWS];
  logic [N:0][WIDTH-1:0] rd_row;
  logic wr_en, wr_last, rd_acc, rd_rej, rd_bad, rd_step, rd_last;

  assign wr_last = (wrow == RW'(ROWS - 1)) && (widx == IW'(N));
  assign rd_last = (rptr == PW'(N - 1));
  assign rd_bad  = (32'(rd_layer) >= M);
  assign rd_row  = mem[rrow];

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    rd_acc   = 1'b0;
    rd_rej   = 1'b0;
    rd_step  = 1'b0;
    ld_ready = (state == LOAD);
    rd_ready = (state == RDY);
    loaded   = (state == RDY) || (state == READ);
    // ld_start overrides everything: the word or request presented with it is dropped
    if (ld_start) state_nx = LOAD;
    else begin
      case (state)
        LOAD: if (ld_valid) begin
          wr_en = 1'b1;
          if (wr_last) state_nx = RDY;
        end
        RDY: if (rd_req) begin
          if (rd_bad) rd_rej = 1'b1;
          else begin
            rd_acc   = 1'b1;
            state_nx = READ;
          end
        end
        READ: begin
          rd_step = 1'b1;
          if (rd_last) state_nx = RDY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wrow        <= '0;
      widx        <= '0;
      rrow        <= '0;
      rptr        <= '0;
      rd_valid    <= 1'b0;
      rd_err      <= 1'b0;
      weights_out <= '0;
    end else begin
      state    <= state_nx;
      rd_valid <= rd_step && rd_last;
      rd_err   <= rd_rej;
      if (ld_start) begin
        wrow <= '0;
        widx <= '0;
      end else if (wr_en) begin
        if (widx == IW'(N)) begin
          widx <= '0;
          wrow <= wrow + 1'b1;
        end else widx <= widx + 1'b1;
      end
      if (rd_acc) begin
        rrow <= RW'(32'(rd_layer) * N);
        rptr <= '0;
      end else if (rd_step) begin
        weights_out[rptr] <= rd_row;
        rrow <= rrow + 1'b1;
        rptr <= rptr + 1'b1;
      end
    end
  end

  // storage is intentionally not reset; loaded=0 after reset forces a reload
  always_ff @(posedge clk) begin
    if (wr_en) mem[wrow][widx] <= ld_data;
  end

`ifdef WB_PARITY_EN
  logic [N:0] par_mem [ROWS];
  logic [N:0] par_bad;

  always_ff @(posedge clk) begin
    if (wr_en) par_mem[wrow][widx] <= ^ld_data;
  end

  for (genvar i = 0; i <= N; i++) begin : g_par
    assign par_bad[i] = (^rd_row[i]) != par_mem[rrow][i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   parity_err <= 1'b0;
    else if (ld_start)            parity_err <= 1'b0;
    else if (rd_step && |par_bad) parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_weight_buffer.sv
// Bench for weight_buffer (N=2, M=3, WIDTH=8): vector table of reads, random reloads/reads against a flat word model.
module tb_weight_buffer;
  localparam int N = 2, M = 3, WIDTH = 8, LW = 2, WORDS = M * N * (N + 1);
  typedef logic [N-1:0][N:0][WIDTH-1:0] rows_t;
  typedef struct { logic [LW-1:0] layer; bit err; rows_t rows; } vec_t;

  logic clk = 0, rst_n = 0, ld_start = 0, ld_valid = 0, rd_req = 0;
  logic [WIDTH-1:0] ld_data = '0;
  logic [LW-1:0] rd_layer = '0;
  logic ld_ready, loaded, rd_ready, rd_valid, rd_err, parity_err;
  rows_t weights_out;

  int vectors = 0, miscompares = 0;
  logic [WIDTH-1:0] model [WORDS];
  rows_t last_rows;
  vec_t tbl [4];

  always #5 clk = ~clk;

  weight_buffer #(.N(N), .M(M), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .loaded(loaded), .rd_req(rd_req), .rd_layer(rd_layer), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_err(rd_err), .weights_out(weights_out), .parity_err(parity_err));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // expected layer contents straight from the flat word order: layer, neuron, index
  function automatic rows_t rows_of(input int layer);
    rows_t r;
    for (int n = 0; n < N; n++)
      for (int i = 0; i <= N; i++) r[n][i] = model[layer * N * (N + 1) + n * (N + 1) + i];
    return r;
  endfunction

  task automatic push_words(input int cnt, input bit pattern);
    logic [WIDTH-1:0] v;
    for (int k = 0; k < cnt; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        ld_valid = 0;
        @(negedge clk);
      end
      v = pattern ? WIDTH'(k - 5) : WIDTH'($urandom);
      model[k] = v;
      ld_valid = 1;
      ld_data  = v;
      chk("ld_ready_in_load", {63'd0, ld_ready}, 1);
      chk("loaded_in_load", {63'd0, loaded}, 0);
      @(negedge clk);
    end
    ld_valid = 0;
  endtask

  task automatic do_load(input bit pattern);
    ld_start = 1; ld_valid = 1; ld_data = 8'h55;   // word with ld_start must be dropped
    @(negedge clk);
    ld_start = 0; ld_valid = 0;
    push_words(WORDS, pattern);
    chk("loaded_after_last", {63'd0, loaded}, 1);
    chk("ld_ready_after_last", {63'd0, ld_ready}, 0);
    ld_valid = 1; ld_data = 8'h7f;                 // no wrap: must be ignored
    @(negedge clk);
    ld_valid = 0;
  endtask

  task automatic do_read(input string nm, input logic [LW-1:0] layer, input bit exp_err, input rows_t exp_rows);
    int cyc;
    chk({nm, "_rd_ready"}, {63'd0, rd_ready}, 1);
    rd_req = 1; rd_layer = layer;
    @(negedge clk);
    rd_req = 0; cyc = 1;
    if (!exp_err) chk({nm, "_rd_ready_busy"}, {63'd0, rd_ready}, 0);
    while (!rd_valid && !rd_err && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_err"}, {63'd0, rd_err}, {63'd0, exp_err});
    chk({nm, "_valid"}, {63'd0, rd_valid}, {63'd0, !exp_err});
    chk({nm, "_latency"}, cyc, exp_err ? 1 : N + 1);
    chk({nm, "_rows"}, weights_out, exp_rows);
    @(negedge clk);
    chk({nm, "_pulse_end"}, {62'd0, rd_valid, rd_err}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rows_t r;
    tbl[0] = '{layer: 2'd1, err: 1'b0, rows: {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}};
    tbl[1] = '{layer: 2'd3, err: 1'b1, rows: {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}};
    tbl[2] = '{layer: 2'd2, err: 1'b0, rows: {8'd12, 8'd11, 8'd10, 8'd9, 8'd8, 8'd7}};
    tbl[3] = '{layer: 2'd0, err: 1'b0, rows: {8'h00, 8'hff, 8'hfe, 8'hfd, 8'hfc, 8'hfb}};

    repeat (2) @(negedge clk);
    chk("reset_outs", {57'd0, ld_ready, loaded, rd_ready, rd_valid, rd_err, parity_err, 1'b0}, 0);
    chk("reset_weights", weights_out, 0);
    rst_n = 1;
    rd_req = 1; rd_layer = 0;                       // ignored in IDLE
    repeat (2) @(negedge clk);
    chk("idle_ignores_rd", {61'd0, rd_ready, rd_valid, rd_err}, 0);
    rd_req = 0;

    do_load(1'b1);
    foreach (tbl[i]) do_read($sformatf("tbl%0d", i), tbl[i].layer, tbl[i].err, tbl[i].rows);

    // back-to-back: rd_req held through rd_valid, next layer accepted immediately
    rd_req = 1; rd_layer = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 3) begin
        chk("b2b_first_rows", weights_out, tbl[0].rows);
        rd_layer = 2;
      end
      if (c == 4) rd_req = 0;
      chk($sformatf("b2b_valid_c%0d", c), {63'd0, rd_valid}, {63'd0, (c == 3 || c == 6)});
    end
    chk("b2b_second_rows", weights_out, tbl[2].rows);

    // ld_start with rd_req in RDY: load wins, no read
    @(negedge clk);
    rd_req = 1; rd_layer = 0; ld_start = 1;
    @(negedge clk);
    rd_req = 0; ld_start = 0;
    chk("ldstart_wins", {61'd0, ld_ready, loaded, rd_ready}, 3'b100);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen += int'(rd_valid) + int'(rd_err);
    end
    chk("ldstart_no_read", seen, 0);
    push_words(5, 1'b0);
    do_load(1'b0);                                  // restart from word 0 with random data
    last_rows = tbl[2].rows;

    for (int t = 0; t < 12; t++) begin
      logic [LW-1:0] l;
      l = LW'($urandom_range(0, 3));
      if (l < M) last_rows = rows_of(int'(l));
      do_read($sformatf("rnd%0d", t), l, l >= M, last_rows);
    end

`ifdef WB_PARITY_EN
    dut.par_mem[1][0] = ~dut.par_mem[1][0];
    do_read("parity_read", 0, 1'b0, rows_of(0));
    chk("parity_err_set", {63'd0, parity_err}, 1);
`endif

    // ld_start during READ aborts without rd_valid
    rd_req = 1; rd_layer = 1;
    @(negedge clk);
    rd_req = 0; ld_start = 1;
    @(negedge clk);
    ld_start = 0;
    seen = 0;
    repeat (3) begin
      chk("abort_ld_ready", {63'd0, ld_ready}, 1);
      seen += int'(rd_valid);
      @(negedge clk);
    end
    chk("abort_no_valid", seen, 0);
    chk("abort_parity_clr", {63'd0, parity_err}, 0);

    // reset in the middle of a load
    push_words(3, 1'b1);
    rst_n = 0;
    @(negedge clk);
    chk("midload_rst_outs", {58'd0, ld_ready, loaded, rd_ready, rd_valid, rd_err, parity_err}, 0);
    chk("midload_rst_weights", weights_out, 0);
    rst_n = 1;
    ld_valid = 1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {62'd0, ld_ready, loaded}, 0);
    ld_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
